// File: rtl/oled_init_sequencer.sv
// oled_init_sequencer: AHB-Lite master that powers up an SSD1331-class OLED.
// After a start pulse it waits PowerDelay cycles, selects normal mode on the
// OLED manager, streams a fixed 14-byte command list (dnc, data, go, then
// poll ready for each byte), and finally hands the panel to auto mode.
module oled_init_sequencer #(
    parameter logic [31:0] BaseAddr   = 32'h4000_0000,
    parameter int          PowerDelay = 1000,
    parameter int          PollLimit  = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int DW = (PowerDelay > 1) ? $clog2(PowerDelay) : 1;
    localparam int PW = (PollLimit > 1) ? $clog2(PollLimit + 1) : 1;
    localparam logic [DW-1:0] DELAY_LOAD = DW'(PowerDelay - 1);
    localparam logic [PW-1:0] POLL_MAX   = PW'(PollLimit);
    localparam logic [3:0]    LAST_IDX   = 4'd13;

    localparam logic [31:0] ADDR_C0 = BaseAddr;
    localparam logic [31:0] ADDR_C1 = BaseAddr + 32'd4;
    localparam logic [31:0] ADDR_C2 = BaseAddr + 32'd8;
    localparam logic [31:0] ADDR_C3 = BaseAddr + 32'd12;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_SET_NORMAL, S_CMD_DNC, S_CMD_DATA,
        S_CMD_GO, S_POLL, S_NEXT, S_SET_AUTO, S_DONE, S_ERROR
    } state_t;

    state_t         state, state_d;
    logic           dphase, dphase_d;     // 0: address phase, 1: data phase
    logic [DW-1:0]  dly_cnt, dly_d;
    logic [PW-1:0]  poll_cnt, poll_d;
    logic [3:0]     idx, idx_d;
    logic           busy_d, done_d, error_d;
    logic           xfer_done;
    logic           is_xfer;
    logic           xfer_wr;
    logic [31:0]    xfer_addr;
    logic [31:0]    xfer_data;
    logic [8:0]     rom_word;
    logic           hrdata_unused;

    // Only the ready flag in bit 0 of C[2] matters to the sequencer.
    assign hrdata_unused = ^HRDATA[31:1];
    assign HSIZE         = 3'b010;

    // Command list: {dnc, byte}; every entry is a command (dnc = 0).
    function automatic logic [8:0] rom_lookup(input logic [3:0] i);
        case (i)
            4'd0:    rom_lookup = {1'b0, 8'hAE};
            4'd1:    rom_lookup = {1'b0, 8'hA0};
            4'd2:    rom_lookup = {1'b0, 8'h72};
            4'd3:    rom_lookup = {1'b0, 8'hA1};
            4'd4:    rom_lookup = {1'b0, 8'h00};
            4'd5:    rom_lookup = {1'b0, 8'hA2};
            4'd6:    rom_lookup = {1'b0, 8'h00};
            4'd7:    rom_lookup = {1'b0, 8'hA4};
            4'd8:    rom_lookup = {1'b0, 8'hA8};
            4'd9:    rom_lookup = {1'b0, 8'h3F};
            4'd10:   rom_lookup = {1'b0, 8'hAD};
            4'd11:   rom_lookup = {1'b0, 8'h8E};
            4'd12:   rom_lookup = {1'b0, 8'hAF};
            4'd13:   rom_lookup = {1'b0, 8'h87};
            default: rom_lookup = 9'h000;
        endcase
    endfunction

    assign rom_word = rom_lookup(idx);

    // State, phase, counters and status flags; reset returns everything to idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            dphase   <= 1'b0;
            dly_cnt  <= '0;
            poll_cnt <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here updates from pre-edge values.
            state    <= state_d;
            dphase   <= dphase_d;
            dly_cnt  <= dly_d;
            poll_cnt <= poll_d;
            idx      <= idx_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

    // Next-state, bus drive and flag updates for the sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state;
        dphase_d  = dphase;
        dly_d     = dly_cnt;
        poll_d    = poll_cnt;
        idx_d     = idx;
        busy_d    = busy;
        done_d    = done;
        error_d   = error;
        is_xfer   = 1'b0;
        xfer_wr   = 1'b1;
        xfer_addr = '0;
        xfer_data = '0;
        HTRANS    = TRANS_IDLE;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HWDATA    = '0;
        xfer_done = dphase && HREADY;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d  = (PowerDelay > 1) ? S_PWR_WAIT : S_SET_NORMAL;
                    dly_d    = DELAY_LOAD;
                    poll_d   = '0;
                    idx_d    = '0;
                    dphase_d = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PWR_WAIT: begin
                if (dly_cnt <= DW'(1)) begin
                    dly_d   = '0;
                    state_d = S_SET_NORMAL;
                end else begin
                    dly_d = dly_cnt - 1'b1;
                end
            end
            S_SET_NORMAL: begin
                is_xfer   = 1'b1;
                xfer_addr = ADDR_C0;
                xfer_data = 32'd1;
                if (xfer_done) state_d = S_CMD_DNC;
            end
            S_CMD_DNC: begin
                is_xfer   = 1'b1;
                xfer_addr = ADDR_C1;
                xfer_data = {31'd0, rom_word[8]};
                if (xfer_done) state_d = S_CMD_DATA;
            end
            S_CMD_DATA: begin
                is_xfer   = 1'b1;
                xfer_addr = ADDR_C3;
                xfer_data = {24'd0, rom_word[7:0]};
                if (xfer_done) state_d = S_CMD_GO;
            end
            S_CMD_GO: begin
                is_xfer   = 1'b1;
                xfer_addr = ADDR_C2;
                if (xfer_done) state_d = S_POLL;
            end
            S_POLL: begin
                is_xfer   = 1'b1;
                xfer_wr   = 1'b0;
                xfer_addr = ADDR_C2;
                if (xfer_done) begin
                    poll_d = poll_cnt + 1'b1;
                    if (HRDATA[0]) begin
                        state_d = S_NEXT;
                    end else if (poll_d == POLL_MAX) begin
                        state_d = S_ERROR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                poll_d = '0;
                if (idx == LAST_IDX) begin
                    state_d = S_SET_AUTO;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = S_CMD_DNC;
                end
            end
            S_SET_AUTO: begin
                is_xfer   = 1'b1;
                xfer_addr = ADDR_C0;
                if (xfer_done) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Non-pipelined transfer: NONSEQ until accepted, then a data phase held until HREADY.
        if (is_xfer) begin
            HADDR  = xfer_addr;
            HWRITE = xfer_wr;
            if (!dphase) begin
                HTRANS = TRANS_NONSEQ;
                if (HREADY) dphase_d = 1'b1;
            end else begin
                if (xfer_wr) HWDATA = xfer_data;
                if (HREADY) dphase_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// tb_oled_init_sequencer: scoreboard bench for the OLED init sequencer.
// A bus monitor pops expected transfers as they complete; a small slave model
// returns the ready flag; a table of runs plus hand-written reset sequences
// drive the scenarios.
module tb_oled_init_sequencer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          PD   = 4;
    localparam int          PL   = 5;
    localparam logic [31:0] C0 = BASE, C1 = BASE + 32'd4, C2 = BASE + 32'd8, C3 = BASE + 32'd12;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic stall;
        logic never_ready;
        logic mid_start;
        logic exp_done;
        logic exp_error;
        int   exp_wr;
        int   exp_rd;
    } row_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, busy, done, error;
    logic [2:0]  HSIZE;

    logic [7:0] rom_bytes [14] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
                                   8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF, 8'h87};

    xfer_t exp_q[$];
    row_t  rows[5];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, ns_delay = -1;
    int wr_cnt = 0, rd_cnt = 0, nonseq_cnt = 0, reads_since_go = 0, low_run = 0;
    logic stall_en = 1'b0, never_ready = 1'b0, ns_wait = 1'b0;
    logic dp_pending = 1'b0, dp_seen = 1'b0, dp_write = 1'b0, ap_hold = 1'b0, ap_write = 1'b0;
    logic [31:0] dp_addr = '0, dp_wdata = '0, ap_addr = '0;

    oled_init_sequencer #(.BaseAddr(BASE), .PowerDelay(PD), .PollLimit(PL)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .HREADY(HREADY), .HRDATA(HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .busy(busy), .done(done), .error(error)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = 1'b1; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic push_read(input logic [31:0] a);
        xfer_t x;
        x.addr = a; x.wr = 1'b0; x.data = '0;
        exp_q.push_back(x);
    endtask

    // Expected bus traffic for one run: ready on the third read, or never ready.
    task automatic push_run(input logic nr);
        push_write(C0, 32'd1);
        for (int i = 0; i < 14; i++) begin
            push_write(C1, 32'd0);
            push_write(C3, {24'd0, rom_bytes[i]});
            push_write(C2, 32'd0);
            for (int k = 0; k < (nr ? PL : 3); k++) push_read(C2);
            if (nr) return;
        end
        push_write(C0, 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge HCLK); #1 start = 1'b1;
        @(posedge HCLK); #1 start = 0;
    endtask

    // Wait-state generator: in stall mode HREADY drops for at most 3 cycles in a row.
    always @(posedge HCLK) begin
        #1;
        if (stall_en && low_run < 3 && $urandom_range(0, 2) != 0) begin
            HREADY = 1'b0;
            low_run++;
        end else begin
            HREADY = 1'b1;
            low_run = 0;
        end
    end

    // Bus monitor and slave model, sampling mid-cycle on the falling edge.
    always @(negedge HCLK) begin
        logic [31:0] rnd;
        xfer_t e;
        cyc++;
        if (!HRESETn) begin
            dp_pending = 1'b0; dp_seen = 1'b0; ap_hold = 1'b0; reads_since_go = 0; ns_wait = 1'b0;
        end else begin
            if (start && !busy) begin
                start_cyc = cyc;
                ns_wait = 1'b1;
            end
            if (dp_pending) begin
                if (dp_seen) begin
                    check("stall_haddr", HADDR, dp_addr);
                    if (dp_write) check("stall_hwdata", HWDATA, dp_wdata);
                end
                dp_seen = 1'b1;
                dp_wdata = HWDATA;
                if (!dp_write) begin
                    rnd = $urandom();
                    HRDATA = {rnd[31:1], (!never_ready && reads_since_go >= 2)};
                end
                if (HREADY) begin
                    dp_pending = 1'b0;
                    if (dp_write) wr_cnt++; else rd_cnt++;
                    if (dp_write && dp_addr == C2) reads_since_go = 0;
                    if (!dp_write) reads_since_go++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_xfer: got addr %h write %b, expected no transfer", dp_addr, dp_write);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_addr", dp_addr, e.addr);
                        check("xfer_write", 32'(dp_write), 32'(e.wr));
                        if (e.wr) check("xfer_wdata", HWDATA, e.data);
                    end
                end
            end else if (HTRANS == 2'b10) begin
                if (ns_wait) begin
                    ns_delay = cyc - start_cyc;
                    ns_wait = 1'b0;
                end
                if (ap_hold) begin
                    check("hold_haddr", HADDR, ap_addr);
                    check("hold_hwrite", 32'(HWRITE), 32'(ap_write));
                end
                if (HREADY) begin
                    nonseq_cnt++;
                    dp_pending = 1'b1; dp_seen = 1'b0;
                    dp_addr = HADDR; dp_write = HWRITE; ap_hold = 1'b0;
                end else begin
                    ap_hold = 1'b1; ap_addr = HADDR; ap_write = HWRITE;
                end
            end
        end
    end

    initial begin
        int n;
        int base_ns;
        logic found;
        //            stall never mid   done  err   wr  rd
        rows[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 44, 42};
        rows[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 44, 42};
        rows[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 44, 42};
        rows[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  4, PL};
        rows[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 44, 42};

        // Reset with no start: bus idle, flags low.
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_htrans", 32'(HTRANS), 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", 32'(HWRITE), 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_hsize", 32'(HSIZE), 32'd2);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check("idle_htrans", 32'(HTRANS), 32'd0);
        check("idle_flags", {29'd0, busy, done, error}, 32'd0);
        check("idle_no_xfers", 32'(nonseq_cnt), 32'd0);

        for (int r = 0; r < 5; r++) begin
            stall_en = rows[r].stall;
            never_ready = rows[r].never_ready;
            wr_cnt = 0; rd_cnt = 0; ns_delay = -1;
            push_run(rows[r].never_ready);
            pulse_start();
            @(negedge HCLK);
            check("start_flags", {29'd0, busy, done, error}, 32'd4);
            if (rows[r].mid_start) begin
                repeat (60) @(posedge HCLK);
                #1 start = 1'b1;
                @(posedge HCLK); #1 start = 1'b0;
                check("mid_start_busy", 32'(busy), 32'd1);
            end
            n = 0;
            while (busy && n < 3000) begin
                @(negedge HCLK);
                n++;
            end
            check("run_finished", 32'(busy), 32'd0);
            stall_en = 1'b0;
            repeat (30) @(negedge HCLK);
            check("end_done", 32'(done), 32'(rows[r].exp_done));
            check("end_error", 32'(error), 32'(rows[r].exp_error));
            check("end_htrans", 32'(HTRANS), 32'd0);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            check("write_count", 32'(wr_cnt), 32'(rows[r].exp_wr));
            check("read_count", 32'(rd_cnt), 32'(rows[r].exp_rd));
            check("first_nonseq_delay", 32'(ns_delay), 32'(PD));
            exp_q.delete();
        end

        // Reset asserted during a poll read: bus and busy drop before the next edge.
        never_ready = 1'b0;
        push_run(1'b0);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b10 && !HWRITE) begin
                found = 1'b1;
                break;
            end
        end
        check("poll_reached", 32'(found), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        check("async_rst_htrans", 32'(HTRANS), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_haddr", HADDR, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        base_ns = nonseq_cnt;
        repeat (40) @(negedge HCLK);
        check("post_rst_no_xfers", 32'(nonseq_cnt), 32'(base_ns));
        check("post_rst_flags", {29'd0, busy, done, error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
